// File: rtl/w65_bus_pkg.sv
// Shared types for the 65C816-style bus initiator: FSM state encoding,
// the captured transaction record and the full bank+address width.
package w65_bus_pkg;

  localparam int VDA_ADDR_BITS = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic                     we;
    logic [VDA_ADDR_BITS-1:0] addr;
    logic [7:0]               wdata;
  } bus_req_t;

endpackage

// File: rtl/w65_bus_master_phi2_gen.sv
// phi2 generator: free-running half-phase counter that toggles phi2 every
// HALF_DIV clks. The strobes mark the clk whose rising edge moves phi2, so the
// FSM can change state on exactly the same edge that phi2 changes.
module phi2_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic phi2,
  output logic fall_pulse,
  output logic rise_pulse,
  output logic last_high
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CNT_LAST);

  // Phase counter and phi2 toggle; phi2 always restarts low out of reset.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      phi2 <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      phi2 <= ~phi2;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

  // The last clk of phi2-high is both the read sample point and the clk
  // before the falling edge; both names are kept for readability at the FSM.
  assign last_high  = phi2 & wrap;
  assign fall_pulse = phi2 & wrap;
  assign rise_pulse = ~phi2 & wrap;

endmodule

// File: rtl/w65_bus_master.sv
// w65_bus_master: bus initiator for the 65C816-style bus. Runs one read or
// write bus cycle per accepted req, muxing the bank byte onto db during
// phi2-low and driving/sampling data during phi2-high.
// Optional build macro: W65_BUS_MASTER_RDY_EN (rdy=0 at the sample point
// repeats the whole bus cycle until the responder is ready).
module w65_bus_master
  import w65_bus_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [VDA_ADDR_BITS-1:0] addr,
  input  logic [7:0]               wdata,
  output logic                     ack,
  output logic [7:0]               rdata,
  output logic                     busy,
  output logic                     phi2,
  output logic [15:0]              ab,
  output logic [7:0]               db_o,
  output logic                     db_oe,
  input  logic [7:0]               db_i,
  output logic                     rwb,
  output logic                     vda,
  output logic                     vpa,
  input  logic                     rdy
);

  bus_state_e state, state_nxt;
  bus_req_t   txn;
  logic       fall_pulse, rise_pulse, last_high;
  logic       accept, done, rdy_ok;

  phi2_gen #(.HALF_DIV(HALF_DIV)) u_phi2 (
    .clk        (clk),
    .reset      (reset),
    .phi2       (phi2),
    .fall_pulse (fall_pulse),
    .rise_pulse (rise_pulse),
    .last_high  (last_high)
  );

`ifdef W65_BUS_MASTER_RDY_EN
  assign rdy_ok = rdy;
`else
  logic unused_rdy;
  assign unused_rdy = rdy;
  assign rdy_ok     = 1'b1;
`endif

  // busy is only low in IDLE, so a request never lands mid-cycle.
  assign accept = req & ~busy;
  assign vpa    = 1'b0;

  // State register; state only moves on phi2 edges, so bus outputs do too.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and bus pin values decoded from the current state.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    vda       = 1'b0;
    rwb       = 1'b1;
    db_oe     = 1'b0;
    db_o      = 8'h00;
    case (state)
      IDLE: begin
        if (busy && fall_pulse) state_nxt = ADDR;
      end
      ADDR: begin
        vda   = 1'b1;
        rwb   = ~txn.we;
        db_oe = 1'b1;
        db_o  = txn.addr[VDA_ADDR_BITS-1:16];
        if (rise_pulse) state_nxt = DATA;
      end
      DATA: begin
        vda   = 1'b1;
        rwb   = ~txn.we;
        db_oe = txn.we;
        db_o  = txn.we ? txn.wdata : 8'h00;
        if (last_high) begin
          if (rdy_ok) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = ADDR;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, handshake flags, held bus address and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      txn   <= '0;
      busy  <= 1'b0;
      ack   <= 1'b0;
      ab    <= 16'h0000;
      rdata <= 8'h00;
    end else begin
      ack <= done;
      if (accept) begin
        txn  <= '{we: we, addr: addr, wdata: wdata};
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == IDLE && state_nxt == ADDR) ab <= txn.addr[15:0];
      if (done && !txn.we) rdata <= db_i;
    end
  end

endmodule

// File: tb/tb_w65_bus_master.sv
// Directed bench for w65_bus_master: one instance at HALF_DIV=2 and one at
// HALF_DIV=1, selected onto a common set of monitor signals by 'sel'.
module tb_w65_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  db_i = 8'hEE;
  logic        rdy = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  logic req_0, req_1;
  assign req_0 = req & ~sel;
  assign req_1 = req & sel;

  logic        ack_0, busy_0, phi2_0, db_oe_0, rwb_0, vda_0, vpa_0;
  logic [7:0]  rdata_0, db_o_0;
  logic [15:0] ab_0;
  logic        ack_1, busy_1, phi2_1, db_oe_1, rwb_1, vda_1, vpa_1;
  logic [7:0]  rdata_1, db_o_1;
  logic [15:0] ab_1;

  w65_bus_master #(.HALF_DIV(2)) u_dut (
    .clk(clk), .reset(reset), .req(req_0), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_0), .rdata(rdata_0), .busy(busy_0), .phi2(phi2_0), .ab(ab_0),
    .db_o(db_o_0), .db_oe(db_oe_0), .db_i(db_i), .rwb(rwb_0), .vda(vda_0),
    .vpa(vpa_0), .rdy(rdy)
  );

  w65_bus_master #(.HALF_DIV(1)) u_dut_hd1 (
    .clk(clk), .reset(reset), .req(req_1), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_1), .rdata(rdata_1), .busy(busy_1), .phi2(phi2_1), .ab(ab_1),
    .db_o(db_o_1), .db_oe(db_oe_1), .db_i(db_i), .rwb(rwb_1), .vda(vda_1),
    .vpa(vpa_1), .rdy(rdy)
  );

  logic        mon_ack, mon_busy, mon_phi2, mon_db_oe, mon_rwb, mon_vda, mon_vpa;
  logic [7:0]  mon_rdata, mon_db_o;
  logic [15:0] mon_ab;
  assign mon_ack   = sel ? ack_1   : ack_0;
  assign mon_busy  = sel ? busy_1  : busy_0;
  assign mon_phi2  = sel ? phi2_1  : phi2_0;
  assign mon_db_oe = sel ? db_oe_1 : db_oe_0;
  assign mon_rwb   = sel ? rwb_1   : rwb_0;
  assign mon_vda   = sel ? vda_1   : vda_0;
  assign mon_vpa   = sel ? vpa_1   : vpa_0;
  assign mon_rdata = sel ? rdata_1 : rdata_0;
  assign mon_db_o  = sel ? db_o_1  : db_o_0;
  assign mon_ab    = sel ? ab_1    : ab_0;

`ifdef W65_BUS_MASTER_RDY_EN
  localparam int RDY_LOWS = 3;
`else
  localparam int RDY_LOWS = 1;
`endif

  // {phi2, ab, db_o, db_oe, rwb, vda, vpa, ack, rdata, busy}
  localparam logic [38:0] RST_SNAP = {1'b0, 16'h0000, 8'h00, 1'b0, 1'b1,
                                      1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

  function automatic logic [38:0] snap();
    return {mon_phi2, mon_ab, mon_db_o, mon_db_oe, mon_rwb, mon_vda, mon_vpa,
            mon_ack, mon_rdata, mon_busy};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0;
    #1;
    total_cnt++;
    if (snap() !== RST_SNAP) $display("FAIL reset_hd2: got %h want %h", snap(), RST_SNAP);
    else pass_cnt++;
    sel = 1'b1;
    #1;
    total_cnt++;
    if (snap() !== RST_SNAP) $display("FAIL reset_hd1: got %h want %h", snap(), RST_SNAP);
    else pass_cnt++;
    sel = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One transaction with a bus monitor and a responder model; rdy is held
  // low for the first 'stalls' bus cycles.
  task automatic run_txn(input string name, input int hd, input logic w,
                         input logic [23:0] a, input logic [7:0] d,
                         input logic [7:0] rd, input int stalls, input int exp_lows);
    int acks = 0, bus_bad = 0, hs_bad = 0, lows = 0, ack_at = -1;
    int budget = (stalls + 6) * 2 * hd + 4;
    logic prev_addr_ph = 1'b0, addr_ph;
    logic prev_phi2 = mon_phi2, prev_oe = mon_db_oe;
    logic [7:0] rdata_at_ack = 8'hxx;
    rdy   = (stalls == 0);
    we    = w;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    total_cnt++;
    if (mon_busy !== 1'b1) $display("FAIL %s busy_after_req: got %b want 1", name, mon_busy);
    else pass_cnt++;
    for (int i = 1; i <= budget; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      addr_ph = mon_vda & ~mon_phi2;
      if (addr_ph && !prev_addr_ph) begin
        lows++;
        rdy = (lows > stalls);
      end
      if (mon_db_oe !== prev_oe && mon_phi2 === prev_phi2) bus_bad++;
      if (addr_ph && {mon_ab, mon_db_o, mon_db_oe, mon_rwb} !== {a[15:0], a[23:16], 1'b1, ~w})
        bus_bad++;
      if (mon_vda && mon_phi2 &&
          (mon_ab !== a[15:0] || mon_rwb !== ~w || mon_db_oe !== w || (w && mon_db_o !== d)))
        bus_bad++;
      db_i = (mon_vda && mon_phi2 && mon_rwb) ? rd : 8'hEE;
      if (mon_ack) begin
        acks++;
        if (ack_at < 0) ack_at = i;
        rdata_at_ack = mon_rdata;
        if (mon_busy !== 1'b0 || mon_db_oe !== 1'b0) hs_bad++;
      end
      if (acks > 0 && mon_vda) hs_bad++;
      if (acks == 0 && mon_busy !== 1'b1) hs_bad++;
      prev_addr_ph = addr_ph;
      prev_phi2    = mon_phi2;
      prev_oe      = mon_db_oe;
    end
    total_cnt++;
    if (acks != 1) $display("FAIL %s ack_count: got %0d want 1", name, acks);
    else pass_cnt++;
    total_cnt++;
    if (bus_bad != 0) $display("FAIL %s bus_pins: got %0d bad samples want 0", name, bus_bad);
    else pass_cnt++;
    total_cnt++;
    if (hs_bad != 0) $display("FAIL %s handshake: got %0d bad samples want 0", name, hs_bad);
    else pass_cnt++;
    total_cnt++;
    if (lows != exp_lows) $display("FAIL %s bus_cycles: got %0d want %0d", name, lows, exp_lows);
    else pass_cnt++;
    if (stalls == 0) begin
      total_cnt++;
      if (ack_at < 1 || ack_at > 3 * 2 * hd + 1)
        $display("FAIL %s latency: got %0d clks want 1..%0d", name, ack_at, 3 * 2 * hd + 1);
      else pass_cnt++;
    end
    if (!w) begin
      total_cnt++;
      if (rdata_at_ack !== rd) $display("FAIL %s rdata: got %h want %h", name, rdata_at_ack, rd);
      else pass_cnt++;
    end
    rdy  = 1'b1;
    db_i = 8'hEE;
  endtask

  task automatic test_write();
    run_txn("write", 2, 1'b1, 24'h01_1234, 8'hA5, 8'h00, 0, 1);
  endtask

  task automatic test_read();
    run_txn("read", 2, 1'b0, 24'h00_C000, 8'h00, 8'h5A, 0, 1);
  endtask

  task automatic test_rdy_wait();
    run_txn("rdy_wait", 2, 1'b0, 24'h7F_0042, 8'h00, 8'h99, 2, RDY_LOWS);
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_a [3];
    logic [15:0] seen [3];
    int acks = 0, phases = 0, rd_bad = 0, tail_bad = 0;
    logic prev_addr_ph = 1'b0, addr_ph;
    exp_a[0] = 24'h00_0010;
    exp_a[1] = 24'h00_0011;
    exp_a[2] = 24'h00_0012;
    rdy  = 1'b1;
    we   = 1'b0;
    addr = exp_a[0];
    req  = 1'b1;
    for (int i = 0; i < 120 && acks < 3; i++) begin
      @(posedge clk);
      #1;
      addr_ph = mon_vda & ~mon_phi2;
      if (addr_ph && !prev_addr_ph) begin
        if (phases < 3) seen[phases] = mon_ab;
        phases++;
      end
      prev_addr_ph = addr_ph;
      db_i = (mon_vda && mon_phi2 && mon_rwb) ? (mon_ab[7:0] ^ 8'h3C) : 8'hEE;
      if (mon_ack) begin
        if (mon_rdata !== (exp_a[acks][7:0] ^ 8'h3C)) rd_bad++;
        acks++;
        if (acks < 3) begin
          addr = exp_a[acks];
          req  = 1'b1;
        end else begin
          req  = 1'b0;
        end
      end else if (mon_busy) begin
        req  = ~req;
        addr = 24'hFF_FFFF;
      end
    end
    req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (mon_ack || mon_vda) tail_bad++;
    end
    db_i = 8'hEE;
    total_cnt++;
    if (acks != 3) $display("FAIL b2b ack_count: got %0d want 3", acks);
    else pass_cnt++;
    total_cnt++;
    if (phases != 3) $display("FAIL b2b bus_cycles: got %0d want 3", phases);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (seen[k] !== exp_a[k][15:0])
        $display("FAIL b2b ab_cycle%0d: got %h want %h", k, seen[k], exp_a[k][15:0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (rd_bad != 0) $display("FAIL b2b rdata: got %0d bad acks want 0", rd_bad);
    else pass_cnt++;
    total_cnt++;
    if (tail_bad != 0) $display("FAIL b2b tail_idle: got %0d busy samples want 0", tail_bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    bit found = 0;
    int rst_bad = 0, post_acks = 0;
    logic first_phi2;
    we    = 1'b1;
    addr  = 24'h02_BEEF;
    wdata = 8'h3C;
    req   = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mon_vda && mon_phi2) found = 1;
    end
    total_cnt++;
    if (!found) $display("FAIL abort reach_data_phase: got timeout want data phase");
    else pass_cnt++;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (snap() !== RST_SNAP) rst_bad++;
    end
    reset = 1'b0;
    total_cnt++;
    if (rst_bad != 0) $display("FAIL abort reset_values: got %0d bad samples want 0", rst_bad);
    else pass_cnt++;
    @(posedge clk);
    #1;
    first_phi2 = mon_phi2;
    for (int i = 0; i < 8; i++) begin
      if (mon_ack || mon_vda || mon_busy) post_acks++;
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (first_phi2 !== 1'b0) $display("FAIL abort phi2_restart: got %b want 0", first_phi2);
    else pass_cnt++;
    total_cnt++;
    if (post_acks != 0) $display("FAIL abort no_ack: got %0d active samples want 0", post_acks);
    else pass_cnt++;
  endtask

  task automatic test_half_div1();
    int tog_bad = 0;
    logic prev;
    sel = 1'b1;
    @(posedge clk);
    #1;
    prev = mon_phi2;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (mon_phi2 === prev) tog_bad++;
      prev = mon_phi2;
    end
    total_cnt++;
    if (tog_bad != 0) $display("FAIL hd1 phi2_toggle: got %0d stuck clks want 0", tog_bad);
    else pass_cnt++;
    run_txn("hd1_write", 1, 1'b1, 24'h03_5678, 8'hC3, 8'h00, 0, 1);
    sel = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rdy_wait();
    test_back_to_back();
    test_reset_abort();
    test_half_div1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/w65_bus_master.md
# w65_bus_master

Bus initiator for the 65C816-style bus the FPGA decode logic responds to: generates `phi2`, multiplexes the bank byte onto `db` during phi2-low, drives address/`rwb`/`vda`, and drives or samples data during phi2-high. It lets on-chip logic (DMA, self-test, or CPU replacement while `BE` is low) run bus cycles against the same ROM/RAM/ACIA decode without the 65C816 present. Accepts one transaction at a time via a req/ack handshake.

## Interface
- `HALF_DIV`, 2: `clk` cycles per phi2 half-phase; legal range 1..255.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  transaction request; sampled only when `busy`=0.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  24  {bank, address}; captured with `req`.
- `wdata`  in  8  write data; captured with `req`.
- `ack`  out  1  one-clk pulse: transaction complete.
- `rdata`  out  8  read data; valid from `ack` until next `ack`.
- `busy`  out  1  transaction accepted and not yet acked.
- `phi2`  out  1  bus clock, free-running, 50% duty.
- `ab`  out  16  bus address.
- `db_o`  out  8  data/bank out; `db_oe`  out  1  tristate enable (top owns the pad).
- `db_i`  in  8  data bus sampled.
- `rwb`  out  1  1 = read; `vda`  out  1; `vpa`  out  1 (tied 0).
- `rdy`  in  1  responder ready (see Configuration).

## Operation
- Phase counter `cnt` 0..HALF_DIV-1; at `cnt`=HALF_DIV-1 it wraps and `phi2` toggles. Bus cycle = 2·HALF_DIV clks.
- States: IDLE, ADDR (phi2 low), DATA (phi2 high).
- IDLE: `vda`=0, `rwb`=1, `db_oe`=0, `ab` holds. If `req`=1 and `busy`=0: capture `we/addr/wdata`, `busy`=1 next clk. Transaction starts at the next phi2 falling edge; a request accepted during phi2-low waits for the following falling edge (no partial phases).
- ADDR (whole phi2-low half): `ab`=addr[15:0], `vda`=1, `rwb`=~we, `db_o`=addr[23:16], `db_oe`=1.
- DATA (whole phi2-high half): `ab/vda/rwb` held. Write: `db_o`=wdata, `db_oe`=1. Read: `db_oe`=0; `rdata`←`db_i` on the last clk of phi2-high (`cnt`=HALF_DIV-1).
- Completion at that same sample clk: `ack`=1 for one clk next edge, `busy`=0, state→IDLE at the phi2 falling edge (`db_oe`=0, `vda`=0).
- `req` held high across `ack`: next transaction accepted the clk after `busy` falls and starts at the next falling edge — back-to-back cycles with no idle bus cycle only if accepted before that edge; otherwise one idle cycle.
- Address width: bank is addr[23:16], no wrap arithmetic performed.

## Timing
- Reset values: `phi2`=0, `cnt`=0, state IDLE, `ab`=0, `db_o`=0, `db_oe`=0, `rwb`=1, `vda`=0, `vpa`=0, `ack`=0, `rdata`=0, `busy`=0.
- Reset mid-transaction: aborts, no `ack`, `db_oe`/`vda` low on the next clk; `phi2` restarts low.
- `req` during `busy`=1: ignored, no queuing.
- Latency (HALF_DIV=2, req accepted on clk where phi2 just went low): worst case `ack` ≤ 3·2·HALF_DIV+1 clks after `req`.
- `db_oe` changes only at phi2 edges; bank never driven during phi2-high.

## Configuration
- `W65_BUS_MASTER_RDY_EN` defined: at the DATA sample point, `rdy`=0 inserts a wait state — phi2 keeps running, a full bus cycle repeats with identical `ab/vda/rwb/db_o`, sample retried; `ack` only when `rdy`=1 at sample. Unbounded wait allowed; reset is the escape.
- Not defined: `rdy` ignored; every transaction is exactly one bus cycle.

## Structure
- Package `w65_bus_pkg`: state enum (IDLE/ADDR/DATA), `bus_req_t` struct {we, addr[23:0], wdata[7:0]}, `VDA_ADDR_BITS`=24 constant.
- Sub-module `phi2_gen`: phase counter and `phi2` toggle, outputs `fall_pulse`, `last_high` strobes consumed by the FSM.

## Test plan
- Reset held 3 clks mid-write -> all outputs at reset values next clk, no `ack`.
- Write addr=0x01_1234, wdata=0xA5, HALF_DIV=2 -> phi2-low: `ab`=0x1234, `db_o`=0x01, `rwb`=0; phi2-high: `db_o`=0xA5; one `ack`.
- Read addr=0x00_C000, model drives `db_i`=0x5A in phi2-high -> `rwb`=1, `db_oe`=0 in high phase, `rdata`=0x5A at `ack`.
- `req` held high for 3 reads at 0x10,0x11,0x12 -> three distinct acks, `req` pulses during `busy` ignored, no overlapped cycles.
- With `W65_BUS_MASTER_RDY_EN`, `rdy`=0 for 2 sample points -> bus cycle repeated twice with same `ab`, `ack` on 3rd sample; without the macro -> `ack` after first cycle.
- HALF_DIV=1 -> `phi2` toggles every clk, write still completes with correct bank/data sequencing.
